// File: rtl/xio_pkg.sv
// Shared types for the xio SDRAM access path: FSM states and posted-write entries.
package xio_pkg;

  // Default SDRAM byte-address width seen by the A8 aperture stage.
  localparam int ADDR_W_DEFAULT = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } bridge_state_t;

  // One posted write at the default address width.
  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] addr;
    logic [7:0]                data;
  } wr_entry_t;

endpackage

// File: rtl/xio_wr_fifo.sv
// Posted-write FIFO with a combinational address lookup that returns the
// youngest matching entry, used for store-to-load forwarding.
module xio_wr_fifo #(
  parameter int ADDR_W = 27,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [7:0]        push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [7:0]        head_data_o,
  input  logic [ADDR_W-1:0] lk_addr_i,
  output logic              lk_hit_o,
  output logic [7:0]        lk_data_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_s;
  logic              push_s;
  logic              pop_s;
  logic [IW-1:0]     idx_s;
  logic              match_s;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [7:0]        data_mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o      = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign count_s     = wr_ptr_q - rd_ptr_q;
  assign head_addr_o = addr_mem_q[rd_ptr_q[IW-1:0]];
  assign head_data_o = data_mem_q[rd_ptr_q[IW-1:0]];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_s = push_i && (!full_o || pop_i);
  assign pop_s  = pop_i && !empty_o;

  // Next-state pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{IW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{IW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= {ADDR_W{1'b0}};
        data_mem_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      addr_mem_q[wr_ptr_q[IW-1:0]] <= push_addr_i;
      data_mem_q[wr_ptr_q[IW-1:0]] <= push_data_i;
    end
  end

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lk_hit_o  = 1'b0;
    lk_data_o = 8'h00;
    idx_s     = {IW{1'b0}};
    match_s   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s     = rd_ptr_q[IW-1:0] + IW'(i);
      match_s   = (PW'(i) < count_s) && (addr_mem_q[idx_s] == lk_addr_i);
      lk_hit_o  = lk_hit_o | match_s;
      lk_data_o = match_s ? data_mem_q[idx_s] : lk_data_o;
    end
  end

endmodule

// File: rtl/sdram_access_bridge.sv
// Turns resolved A8 accesses into SDRAM controller requests: posted writes
// through a FIFO, reads with priority and store-to-load forwarding, and read
// data held on the A8 bus until the A8 clock falls.
module sdram_access_bridge
  import xio_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              a8_rst_n,
  input  logic              acc_valid,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              acc_rw,
  input  logic [7:0]        acc_wdata,
  input  logic              a8_clk_falling,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        rd_data,
  output logic              rd_data_oe,
  output logic              busy,
  output logic              overflow,
  output logic              timeout
);

  bridge_state_t     state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              slot_vld_q, slot_vld_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic              aband_q, aband_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_oe_q, rd_oe_d;
  logic              ovf_q, ovf_d;
  logic              tmo_q, tmo_d;

  logic              acc_rd_s, acc_wr_s, fwd_s, miss_s, kill_s;
  logic              inflight_s, pop_s, push_s, deliver_s;
  logic              full_s, empty_s, lk_hit_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [7:0]        head_data_s, lk_data_s;

  assign acc_rd_s   = acc_valid & acc_rw;
  assign acc_wr_s   = acc_valid & ~acc_rw;
  assign fwd_s      = acc_rd_s & lk_hit_s;
  assign miss_s     = acc_rd_s & ~lk_hit_s;
  // A new read or the end of the A8 cycle retires whatever read came before.
  assign kill_s     = a8_clk_falling | acc_rd_s;
  assign inflight_s = (state_q == RD_REQ) || (state_q == RD_WAIT);
  assign pop_s      = (state_q == WR_REQ) && mem_ack;
  assign push_s     = acc_wr_s && (!full_s || pop_s);

  xio_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wr_fifo (
    .clk         (clk),
    .rst_n       (a8_rst_n),
    .push_i      (push_s),
    .push_addr_i (acc_addr),
    .push_data_i (acc_wdata),
    .pop_i       (pop_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s),
    .lk_addr_i   (acc_addr),
    .lk_hit_o    (lk_hit_s),
    .lk_data_o   (lk_data_s)
  );

  // Next-state logic: request FSM, read slot, A8 read-data and sticky flags.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    aband_d     = aband_q;
    rd_data_d   = rd_data_q;
    rd_oe_d     = rd_oe_q;
    ovf_d       = ovf_q | (acc_wr_s & full_s & ~pop_s);
    tmo_d       = tmo_q | (kill_s & (slot_vld_q | (inflight_s & ~aband_q)));
    deliver_s   = 1'b0;

    // A superseded slot read is dropped; a new miss parks here unless IDLE issues it now.
    if (kill_s) begin
      slot_vld_d = 1'b0;
    end else begin
      slot_vld_d = slot_vld_q;
    end
    if (miss_s && (state_q != IDLE)) begin
      slot_vld_d  = 1'b1;
      slot_addr_d = acc_addr;
    end else begin
      slot_addr_d = slot_addr_q;
    end

    case (state_q)
      IDLE: begin
        aband_d = 1'b0;
        if (miss_s) begin
          state_d     = RD_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = acc_addr;
          mem_wdata_d = 8'h00;
        end else if (slot_vld_q && !kill_s) begin
          state_d     = RD_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = slot_addr_q;
          mem_wdata_d = 8'h00;
          slot_vld_d  = 1'b0;
        end else if (!empty_s) begin
          state_d     = WR_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr_s;
          mem_wdata_d = head_data_s;
        end else if (acc_wr_s) begin
          // Empty FIFO: the write being pushed now becomes the head, issue it directly.
          state_d     = WR_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = acc_addr;
          mem_wdata_d = acc_wdata;
        end else begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      WR_REQ: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        aband_d = aband_q | kill_s;
        if (mem_ack) begin
          state_d   = RD_WAIT;
          mem_req_d = 1'b0;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        aband_d = aband_q | kill_s;
        if (mem_rvalid) begin
          state_d   = IDLE;
          deliver_s = ~(aband_q | kill_s);
        end else begin
          state_d = RD_WAIT;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    // Falling edge ends the bus cycle; a forward belongs to the newer access and wins.
    if (a8_clk_falling) begin
      rd_oe_d = 1'b0;
    end else begin
      rd_oe_d = rd_oe_q;
    end
    if (fwd_s) begin
      rd_data_d = lk_data_s;
      rd_oe_d   = 1'b1;
    end else if (deliver_s) begin
      rd_data_d = mem_rdata;
      rd_oe_d   = 1'b1;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State and output registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 8'h00;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= {ADDR_W{1'b0}};
      aband_q     <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_oe_q     <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      aband_q     <= aband_d;
      rd_data_q   <= rd_data_d;
      rd_oe_q     <= rd_oe_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rd_data    = rd_data_q;
  assign rd_data_oe = rd_oe_q;
  assign overflow   = ovf_q;
  assign timeout    = tmo_q;
  assign busy       = ~empty_s | slot_vld_q | (state_q != IDLE);

endmodule

// File: tb/tb_sdram_access_bridge.sv
// Directed bench for sdram_access_bridge with hand-computed expectations.
module tb_sdram_access_bridge;

  logic        clk = 1'b0;
  logic        a8_rst_n = 1'b0;
  logic        acc_valid = 1'b0;
  logic [26:0] acc_addr = 27'd0;
  logic        acc_rw = 1'b0;
  logic [7:0]  acc_wdata = 8'h00;
  logic        a8_clk_falling = 1'b0;
  logic        mem_req, mem_we;
  logic [26:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  rd_data;
  logic        rd_data_oe, busy, overflow, timeout;

  int n_cmp = 0;
  int n_err = 0;

  sdram_access_bridge dut (
    .clk            (clk),
    .a8_rst_n       (a8_rst_n),
    .acc_valid      (acc_valid),
    .acc_addr       (acc_addr),
    .acc_rw         (acc_rw),
    .acc_wdata      (acc_wdata),
    .a8_clk_falling (a8_clk_falling),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rd_data        (rd_data),
    .rd_data_oe     (rd_data_oe),
    .busy           (busy),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic rw, input logic [26:0] a, input logic [7:0] d);
    acc_valid = 1'b1;
    acc_rw    = rw;
    acc_addr  = a;
    acc_wdata = d;
    tick();
    acc_valid = 1'b0;
    acc_rw    = 1'b0;
  endtask

  task automatic pulse_ack();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic pulse_fall();
    a8_clk_falling = 1'b1;
    tick();
    a8_clk_falling = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 20 && mem_req !== 1'b1; n++) tick();
    chk(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic drain(input string tag, input logic [26:0] a, input logic [7:0] d);
    wait_req({tag, "_req"});
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
    pulse_ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    #2 a8_rst_n = 1'b1;
    tick();

    // Posted write, ack three cycles after the request
    acc(1'b0, 27'h0000100, 8'h5A);
    chk("w1_req", 32'(mem_req), 32'd1);
    chk("w1_we", 32'(mem_we), 32'd1);
    chk("w1_addr", 32'(mem_addr), 32'h100);
    chk("w1_wdata", 32'(mem_wdata), 32'h5A);
    chk("w1_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("w1_req_hold", 32'(mem_req), 32'd1);
    pulse_ack();
    chk("w1_req_drop", 32'(mem_req), 32'd0);
    chk("w1_busy_fall", 32'(busy), 32'd0);

    // Read miss, data six cycles after ack, falling edge twenty cycles later
    acc(1'b1, 27'h0000200, 8'h00);
    chk("r1_req", 32'(mem_req), 32'd1);
    chk("r1_we", 32'(mem_we), 32'd0);
    chk("r1_addr", 32'(mem_addr), 32'h200);
    pulse_ack();
    chk("r1_req_drop", 32'(mem_req), 32'd0);
    repeat (5) tick();
    chk("r1_oe_before", 32'(rd_data_oe), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 8'hC3;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    chk("r1_oe", 32'(rd_data_oe), 32'd1);
    chk("r1_data", 32'(rd_data), 32'hC3);
    repeat (19) tick();
    chk("r1_oe_held", 32'(rd_data_oe), 32'd1);
    pulse_fall();
    chk("r1_oe_clr", 32'(rd_data_oe), 32'd0);
    chk("r1_data_hold", 32'(rd_data), 32'hC3);
    chk("r1_timeout", 32'(timeout), 32'd0);

    // Forwarding from the youngest of two queued writes
    acc(1'b0, 27'h0000300, 8'h11);
    chk("f_req", 32'(mem_req), 32'd1);
    acc(1'b0, 27'h0000300, 8'h22);
    acc(1'b1, 27'h0000300, 8'h00);
    chk("f_data", 32'(rd_data), 32'h22);
    chk("f_oe", 32'(rd_data_oe), 32'd1);
    chk("f_we", 32'(mem_we), 32'd1);
    chk("f_wdata", 32'(mem_wdata), 32'h11);
    tick();
    chk("f_we_later", 32'(mem_we), 32'd1);
    chk("f_timeout", 32'(timeout), 32'd0);
    pulse_fall();
    chk("f_oe_clr", 32'(rd_data_oe), 32'd0);
    drain("f_w0", 27'h0000300, 8'h11);
    drain("f_w1", 27'h0000300, 8'h22);
    chk("f_busy", 32'(busy), 32'd0);

    // Full FIFO with a pop in the same cycle accepts the write
    acc(1'b0, 27'h0000500, 8'h50);
    acc(1'b0, 27'h0000501, 8'h51);
    acc(1'b0, 27'h0000502, 8'h52);
    acc(1'b0, 27'h0000503, 8'h53);
    mem_ack = 1'b1;
    acc(1'b0, 27'h0000504, 8'h54);
    mem_ack = 1'b0;
    chk("fp_ovf", 32'(overflow), 32'd0);
    drain("fp_w1", 27'h0000501, 8'h51);
    drain("fp_w2", 27'h0000502, 8'h52);
    drain("fp_w3", 27'h0000503, 8'h53);
    drain("fp_w4", 27'h0000504, 8'h54);

    // Overflow: fifth write into a full FIFO is dropped
    for (int i = 0; i < 4; i++) acc(1'b0, 27'h0000400 + 27'(i), 8'(i + 1));
    chk("ov_before", 32'(overflow), 32'd0);
    acc(1'b0, 27'h0000404, 8'h05);
    chk("ov_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) drain("ov_w", 27'h0000400 + 27'(i), 8'(i + 1));
    repeat (5) tick();
    chk("ov_no_5th", 32'(mem_req), 32'd0);
    chk("ov_busy", 32'(busy), 32'd0);
    chk("ov_sticky", 32'(overflow), 32'd1);

    // Late read data after the falling edge is discarded
    chk("late_tmo_before", 32'(timeout), 32'd0);
    acc(1'b1, 27'h0000600, 8'h00);
    chk("late_req", 32'(mem_req), 32'd1);
    pulse_ack();
    pulse_fall();
    chk("late_tmo", 32'(timeout), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 8'hEE;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    chk("late_oe", 32'(rd_data_oe), 32'd0);
    chk("late_data", 32'(rd_data), 32'h22);
    chk("late_idle", 32'(busy), 32'd0);

    // Asynchronous reset during RD_WAIT
    acc(1'b1, 27'h0000700, 8'h00);
    pulse_ack();
    chk("ar_busy_before", 32'(busy), 32'd1);
    #1 a8_rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_addr", 32'(mem_addr), 32'h0);
    chk("ar_rd_data", 32'(rd_data), 32'h00);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_tmo", 32'(timeout), 32'd0);
    tick();
    tick();
    #2 a8_rst_n = 1'b1;
    tick();
    acc(1'b0, 27'h0000800, 8'h99);
    chk("ar_w_req", 32'(mem_req), 32'd1);
    chk("ar_w_addr", 32'(mem_addr), 32'h800);
    chk("ar_w_wdata", 32'(mem_wdata), 32'h99);
    pulse_ack();
    chk("ar_w_done", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_access_bridge.md
Name: sdram_access_bridge

Overview:
- Downstream of the aperture/address stage in xio; consumes each resolved A8 access (27-bit SDRAM address, rw, write data) and turns it into SDRAM controller requests over a req/ack/rvalid handshake.
- Writes are posted into a small FIFO. Reads bypass queued writes, with store-to-load forwarding from that FIFO.
- Read data is driven back toward the A8 data bus and held until the A8 clock falls. Late data is flagged and discarded.

Parameters:
ADDR_W, 27, SDRAM byte address width
DEPTH, 4, posted-write FIFO entries (power of 2, >=2)

Ports:
clk  in  1  master clock (200 MHz)
a8_rst_n  in  1  asynchronous active-low reset
acc_valid  in  1  one-cycle pulse per resolved A8 access
acc_addr  in  ADDR_W  SDRAM address of access
acc_rw  in  1  1=read, 0=write
acc_wdata  in  8  A8 write data (valid with acc_valid when acc_rw=0)
a8_clk_falling  in  1  one-cycle pulse; ends current A8 bus cycle
mem_req  out  1  request to SDRAM controller
mem_we  out  1  1=write request
mem_addr  out  ADDR_W  request address
mem_wdata  out  8  request write data
mem_ack  in  1  one-cycle pulse; controller accepted request
mem_rvalid  in  1  one-cycle pulse; read data valid
mem_rdata  in  8  read data
rd_data  out  8  data for A8 bus
rd_data_oe  out  1  drive rd_data onto A8 bus
busy  out  1  FIFO non-empty, read pending, or FSM not IDLE
overflow  out  1  sticky: write dropped on full FIFO
timeout  out  1  sticky: read data missed its A8 cycle

Behaviour:
- Reset values (asynchronous, all outputs): all 0. rd_data=0x00. FIFO empty, read slot empty, FSM in IDLE.
- Reset asserted mid-operation: abort immediately, mem_req drops at once. The controller shares the same reset.
- Write on acc_valid: push {addr,wdata} into the FIFO.
  - Full FIFO: write is dropped, overflow<=1.
  - Full FIFO with a pop (mem_ack on a write) in the same cycle: write is accepted.
- Read on acc_valid: compare acc_addr against all valid FIFO entries.
  - Match: youngest matching entry's data -> rd_data, rd_data_oe=1 on the next cycle. No mem read is issued.
  - No match: load the read slot.
- Read arriving while a previous read is still outstanding: timeout<=1. The old read is marked abandoned; the new read takes the slot once the FSM frees it.
- FSM states:
  - IDLE: if read slot is valid -> RD_REQ (reads have priority); else if FIFO non-empty -> WR_REQ.
  - WR_REQ: mem_req=1, mem_we=1, drives FIFO head. On mem_ack: pop head, go to IDLE. The head stays visible to forwarding until popped.
  - RD_REQ: mem_req=1, mem_we=0. On mem_ack -> RD_WAIT.
  - RD_WAIT: on mem_rvalid -> IDLE. If the read is not abandoned: rd_data<=mem_rdata, rd_data_oe<=1 next cycle.
- mem_req/mem_we/mem_addr/mem_wdata are registered and stable while mem_req=1. mem_req drops the cycle after mem_ack.
- Earliest mem_req is the cycle after acc_valid. mem_req never re-asserts in the same cycle as mem_ack.
- The controller completes requests in order, so a read issued after an acked write observes that write.
- a8_clk_falling:
  - Clears rd_data_oe (rd_data holds).
  - If a read is pending in the slot, RD_REQ or RD_WAIT: mark it abandoned, timeout<=1. An abandoned read still completes its handshake, and its rvalid is discarded.
- acc_valid and a8_clk_falling in the same cycle: the falling edge applies to the previous access; the new access is accepted normally.
- Forward-hit result and mem_rvalid result in the same cycle: the forward is for the newer access and wins, and the rvalid result is treated as abandoned.
- FIFO pointers: log2(DEPTH)+1 bits with wrap-around. Full means MSBs differ and LSBs are equal.
- overflow and timeout clear only on reset.

Decomposition:
- Package xio_pkg:
  - ADDR_W default constant.
  - bridge_state_t enum {IDLE, WR_REQ, RD_REQ, RD_WAIT}.
  - wr_entry_t struct {addr, data}.
- Sub-module xio_wr_fifo:
  - Synchronous FIFO with push/pop/full/empty.
  - Combinational lookup port: address in -> hit + youngest matching data.
- The FSM, read slot and output registers live in sdram_access_bridge.

Test Plan:
- Write 0x5A to 0x0000100, mem_ack 3 cycles after mem_req -> mem_req=1 the cycle after acc_valid with mem_we=1, mem_addr=0x100, mem_wdata=0x5A. mem_req=0 the cycle after ack; busy falls.
- Read 0x0000200, mem_rvalid with 0xC3 6 cycles after ack, a8_clk_falling 20 cycles later -> rd_data=0xC3, rd_data_oe=1 from the cycle after rvalid until the cycle after a8_clk_falling; timeout=0.
- mem_ack held low; write 0x11 then 0x22 to 0x300; read 0x300 -> rd_data=0x22, rd_data_oe=1 the cycle after the read. No mem_we=0 request ever issued.
- mem_ack held low; 5 writes (0x01..0x05) to 0x400..0x404 -> 5th dropped, overflow=1. Release ack -> exactly 4 writes issued in order 0x400..0x403.
- Read with mem_rvalid arriving after a8_clk_falling -> rd_data_oe stays 0, timeout=1. rvalid data not placed on rd_data; FSM returns to IDLE.
- Assert a8_rst_n=0 during RD_WAIT -> all outputs 0 within the same cycle, without a clk edge. After release, a write completes normally.
